// File: rtl/prbs_pkg.sv
// prbs_pkg: PRBS9 polynomial constants and checker state encoding shared by the PRBS blocks.
package prbs_pkg;
    localparam int PRBS_LEN = 9;
    localparam int TAP_A = 8;
    localparam int TAP_B = 4;
    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    typedef enum logic [1:0] {
        FILL = ST_FILL,
        CHECK = ST_CHECK,
        LOCKED = ST_LOCKED
    } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones; synchronous clear beats increment.
module sat_counter #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = i_clr ? '0 : (i_inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign o_cnt = cnt_q;
endmodule

// File: rtl/prbs9_sync_checker.sv
// prbs9_sync_checker: self-synchronising PRBS9 (x^9+x^5+1) receive checker with lock
// acquisition, windowed loss-of-lock detection and saturating bit/error counters.
module prbs9_sync_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int WINDOW = 128,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    input  logic             i_rx,
    input  logic             i_clear,
    output logic             o_lock,
    output logic             o_err,
    output logic [CNT_W-1:0] o_bits,
    output logic [CNT_W-1:0] o_errors
);
    localparam int FW = $clog2(PRBS_LEN + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    state_t state_q, state_d;
    logic [PRBS_LEN-1:0] h_q, h_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [MW-1:0] match_q, match_d;
    logic [WW-1:0] wbits_q, wbits_d;
    logic [EW-1:0] werr_q, werr_d;
    logic err_q, err_d;
    logic pred, mis, locked, bit_inc, err_inc;

    assign pred = h_q[TAP_A] ^ h_q[TAP_B];
    assign mis = i_rx != pred;
    assign locked = state_q == LOCKED;

    always_comb begin
        state_d = state_q;
        h_d = h_q;
        fill_d = fill_q;
        match_d = match_q;
        wbits_d = wbits_q;
        werr_d = werr_q;
        err_d = 1'b0;
        bit_inc = 1'b0;
        err_inc = 1'b0;
        if (i_valid) begin
            // once locked the predictor free-runs, so a flipped bit cannot propagate
            h_d = {h_q[PRBS_LEN-2:0], locked ? pred : i_rx};
            case (state_q)
                FILL: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FW'(PRBS_LEN - 1)) begin
                        state_d = CHECK;
                        fill_d = '0;
                        match_d = '0;
                    end
                end
                CHECK: begin
                    match_d = (h_q == '0 || mis) ? '0 : match_q + 1'b1;
                    if (match_d == MW'(LOCK_COUNT)) state_d = LOCKED;
                end
                LOCKED: begin
                    bit_inc = 1'b1;
                    err_inc = mis;
                    err_d = mis;
                    werr_d = werr_q + EW'(mis);
                    if (werr_d == EW'(LOSS_THRESH)) begin
                        state_d = FILL;
                        h_d = '0;
                        wbits_d = '0;
                        werr_d = '0;
                    end else if (wbits_q == WW'(WINDOW - 1)) begin
                        wbits_d = '0;
                        werr_d = '0;
                    end else begin
                        wbits_d = wbits_q + 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL;
            h_q <= '0;
            fill_q <= '0;
            match_q <= '0;
            wbits_q <= '0;
            werr_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q <= h_d;
            fill_q <= fill_d;
            match_q <= match_d;
            wbits_q <= wbits_d;
            werr_q <= werr_d;
            err_q <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_bits (
        .clock(clock),
        .reset(reset),
        .i_clr(i_clear),
        .i_inc(bit_inc),
        .o_cnt(o_bits)
    );

    sat_counter #(.W(CNT_W)) u_errors (
        .clock(clock),
        .reset(reset),
        .i_clr(i_clear),
        .i_inc(err_inc),
        .o_cnt(o_errors)
    );

    assign o_lock = locked;
    assign o_err = err_q;
endmodule

// File: tb/tb_prbs9_sync_checker.sv
// tb_prbs9_sync_checker: directed and randomized checks of prbs9_sync_checker against
// a behavioural model; a narrow-counter instance exercises saturation.
module tb_prbs9_sync_checker;
    logic clock = 1'b0, reset = 1'b1, i_valid = 1'b0, i_rx = 1'b0, i_clear = 1'b0;
    logic o_lock, o_err, o_lock_s, o_err_s;
    logic [63:0] o_bits, o_errors;
    logic [3:0] o_bits_s, o_errors_s;
    int checks = 0, errors = 0, err_pulses = 0;

    always #5 clock = ~clock;

    prbs9_sync_checker dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_rx(i_rx), .i_clear(i_clear),
        .o_lock(o_lock), .o_err(o_err), .o_bits(o_bits), .o_errors(o_errors)
    );

    prbs9_sync_checker #(.CNT_W(4)) dut_s (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_rx(i_rx), .i_clear(i_clear),
        .o_lock(o_lock_s), .o_err(o_err_s), .o_bits(o_bits_s), .o_errors(o_errors_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // transmitter: any stream obeying x[n] = x[n-9] ^ x[n-5]
    logic [8:0] tx_s = 9'h1AA;
    task automatic next_tx(output logic b);
        b = tx_s[8] ^ tx_s[4];
        tx_s = {tx_s[7:0], b};
    endtask

    // behavioural model: mode 0 = acquiring fill, 1 = checking, 2 = locked
    int mode, fillc, match, wb, we;
    bit hb[9];
    longint mb, me;
    bit m_err;

    task automatic model_step();
        bit p, mis, allz, x;
        if (reset) begin
            mode = 0; fillc = 0; match = 0; wb = 0; we = 0; mb = 0; me = 0; m_err = 0;
            foreach (hb[i]) hb[i] = 0;
        end else begin
            m_err = 0;
            if (i_valid) begin
                p = hb[8] ^ hb[4];
                mis = i_rx != p;
                allz = 1;
                foreach (hb[i]) if (hb[i]) allz = 0;
                x = (mode == 2) ? p : i_rx;
                for (int i = 8; i > 0; i--) hb[i] = hb[i-1];
                hb[0] = x;
                if (mode == 2) begin
                    mb++;
                    me += longint'(mis);
                    m_err = mis;
                    we += int'(mis);
                    if (we >= 16) begin
                        mode = 0; fillc = 0; wb = 0; we = 0;
                        foreach (hb[i]) hb[i] = 0;
                    end else if (wb == 127) begin
                        wb = 0; we = 0;
                    end else wb++;
                end else if (mode == 0) begin
                    fillc++;
                    if (fillc == 9) begin mode = 1; fillc = 0; match = 0; end
                end else begin
                    match = (allz || mis) ? 0 : match + 1;
                    if (match == 16) begin mode = 2; wb = 0; we = 0; end
                end
            end
            if (i_clear) begin mb = 0; me = 0; end
        end
    endtask

    always begin
        @(posedge clock);
        model_step();
        #1;
        if (o_err) err_pulses++;
        chk("cmp_lock", o_lock, mode == 2);
        chk("cmp_err", o_err, m_err);
        chk("cmp_bits", o_bits, mb);
        chk("cmp_errors", o_errors, me);
        chk("cmp_lock_s", o_lock_s, mode == 2);
        chk("cmp_bits_sat", o_bits_s, mb > 15 ? 15 : mb);
        chk("cmp_errors_sat", o_errors_s, me > 15 ? 15 : me);
    end

    task automatic step(input logic v, input logic rx, input logic clr);
        @(negedge clock);
        i_valid = v; i_rx = rx; i_clear = clr;
        @(posedge clock);
        #2;
    endtask

    task automatic send_prbs(input int n, input logic inv);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_tx(b);
            step(1'b1, b ^ inv, 1'b0);
        end
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!o_lock && n < 100) begin
            send_prbs(1, 1'b0);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; i_valid = 1'b0; i_clear = 1'b0;
        @(posedge clock);
        #2;
        chk("rst_lock", o_lock, 0);
        chk("rst_err", o_err, 0);
        chk("rst_bits", o_bits, 0);
        chk("rst_errors", o_errors, 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        logic b, v, inv, clr;
        int burst;
        do_reset();
        // 1: clean stream locks after exactly 25 bits, then 10000 clean bits
        err_pulses = 0;
        wait_lock(n);
        chk("t1_lock_bits", n, 25);
        k = 0;
        while (o_bits < 64'd10000 && k < 20000) begin send_prbs(1, 1'b0); k++; end
        chk("t1_bits", o_bits, 10000);
        chk("t1_errors", o_errors, 0);
        chk("t1_err_pulses", err_pulses, 0);
        // 2: single flipped bit
        send_prbs(1, 1'b1);
        chk("t2_err", o_err, 1);
        chk("t2_errors", o_errors, 1);
        chk("t2_lock", o_lock, 1);
        send_prbs(1, 1'b0);
        chk("t2_err_off", o_err, 0);
        chk("t2_pulses", err_pulses, 1);
        // 3: all-zero stream never locks
        do_reset();
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 1'b0);
        chk("t3_lock", o_lock, 0);
        chk("t3_bits", o_bits, 0);
        // 4: 20 inverted bits cause loss on the 16th error, then relock
        do_reset();
        wait_lock(n);
        chk("t4_lock_bits", n, 25);
        send_prbs(15, 1'b1);
        chk("t4_lock_15", o_lock, 1);
        chk("t4_errors_15", o_errors, 15);
        send_prbs(1, 1'b1);
        chk("t4_lock_16", o_lock, 0);
        chk("t4_errors_16", o_errors, 16);
        send_prbs(4, 1'b1);
        wait_lock(n);
        chk("t4_relock_within_25", n <= 25, 1);
        chk("t4_errors_hold", o_errors, 16);
        // 5: half-rate valid, then clear
        do_reset();
        wait_lock(n);
        for (int i = 0; i < 2000; i++) begin
            if (i % 2 == 0) begin next_tx(b); step(1'b1, b, 1'b0); end
            else step(1'b0, 1'b1, 1'b0);
        end
        chk("t5_bits", o_bits, 1000);
        chk("t5_errors", o_errors, 0);
        chk("t5_lock", o_lock, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("t5_clr_bits", o_bits, 0);
        chk("t5_clr_lock", o_lock, 1);
        next_tx(b);
        step(1'b1, ~b, 1'b1);
        chk("t5_clr_err", o_err, 1);
        chk("t5_clr_errors", o_errors, 0);
        chk("t5_clr_bits2", o_bits, 0);
        // 6: reset mid-lock
        send_prbs(50, 1'b0);
        chk("t6_bits_pre", o_bits, 50);
        do_reset();
        wait_lock(n);
        chk("t6_relock", n, 25);
        // window: 15 errors per window survive, loss on wrap wins
        send_prbs(15, 1'b1);
        send_prbs(113, 1'b0);
        send_prbs(15, 1'b1);
        chk("win_lock", o_lock, 1);
        chk("win_errors", o_errors, 30);
        send_prbs(113, 1'b0);
        send_prbs(112, 1'b0);
        send_prbs(15, 1'b1);
        chk("win_edge_lock_15", o_lock, 1);
        send_prbs(1, 1'b1);
        chk("win_edge_loss", o_lock, 0);
        chk("win_edge_errors", o_errors, 46);
        // random stimulus against the model
        do_reset();
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin do_reset(); burst = 0; end
            v = $urandom_range(0, 9) < 7;
            if (burst == 0 && $urandom_range(0, 799) == 0) burst = 20;
            inv = (burst > 0) || ($urandom_range(0, 63) == 0);
            clr = $urandom_range(0, 299) == 0;
            if (v) begin
                next_tx(b);
                if (burst > 0) burst--;
                step(1'b1, b ^ inv, clr);
            end else step(1'b0, 1'($urandom_range(0, 1)), clr);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
